// File: rtl/ps2_kbd_event_rx_pkg.sv
// Shared scan-code constants, modifier tag layout, event record and decoder state type
// for the PS/2 keyboard event receiver.
package ps2_pkg;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_LCTRL  = 8'h14;
  localparam logic [7:0] CODE_RCTRL  = 8'h14;
  localparam logic [7:0] CODE_LALT   = 8'h11;
  localparam logic [7:0] CODE_RALT   = 8'h11;

  localparam int TAG_LSHIFT = 0;
  localparam int TAG_RSHIFT = 1;
  localparam int TAG_LCTRL  = 2;
  localparam int TAG_RCTRL  = 3;
  localparam int TAG_LALT   = 4;
  localparam int TAG_RALT   = 5;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [5:0] tag;
  } kbdEvent_t;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXTBRK
  } decState_t;

  // One-hot tag bit for a (possibly E0-extended) modifier code, zero otherwise.
  function automatic logic [5:0] modMask(input logic ext, input logic [7:0] code);
    logic [5:0] m;
    m = '0;
    if (!ext && code == CODE_LSHIFT) m[TAG_LSHIFT] = 1'b1;
    if (!ext && code == CODE_RSHIFT) m[TAG_RSHIFT] = 1'b1;
    if (!ext && code == CODE_LCTRL)  m[TAG_LCTRL]  = 1'b1;
    if ( ext && code == CODE_RCTRL)  m[TAG_RCTRL]  = 1'b1;
    if (!ext && code == CODE_LALT)   m[TAG_LALT]   = 1'b1;
    if ( ext && code == CODE_RALT)   m[TAG_RALT]   = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ps2_kbd_event_rx_if.sv
// Key-event stream between the receiver (master) and its consumer (slave).
// Handshake: an event transfers on every CLOCK edge where oValid && iReady; oValid never
// drops and the head never changes until that transfer; fields read 0 while oValid is 0.
interface ps2_kbd_event_rx_if;
  logic       oValid;
  logic       iReady;
  logic [7:0] oData;
  logic       oExt;
  logic       oBreak;
  logic [5:0] oTag;

  modport master (output oValid, oData, oExt, oBreak, oTag, input iReady);
  modport slave  (input oValid, oData, oExt, oBreak, oTag, output iReady);
endinterface

// File: rtl/ps2_kbd_event_rx_frame_rx.sv
// PS/2 frame receiver: synchronises the pins, samples on PS2_CLK falling edges and checks
// start/odd-parity/stop plus an inter-edge timeout; emits one-cycle byte or error strobes.
module ps2_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] byteOut,
  output logic       byteStrobe,
  output logic       frameErr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clkSync;
  logic [SYNC_STAGES-1:0] datSync;
  logic                   clkPrev;
  logic [3:0]             bitCnt;
  logic [7:0]             shiftReg;
  logic                   parBit;
  logic [TW-1:0]          idleCnt;
  logic                   fall;
  logic                   datBit;
  logic                   inFrame;
  logic                   timeout;

  assign fall    = clkPrev & ~clkSync[SYNC_STAGES-1];
  assign datBit  = datSync[SYNC_STAGES-1];
  assign inFrame = (bitCnt != 4'd0);
  assign timeout = inFrame && !fall && (idleCnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      clkSync <= '1;
      datSync <= '1;
      clkPrev <= 1'b1;
    end else begin
      clkSync <= {clkSync[SYNC_STAGES-2:0], PS2_CLK};
      datSync <= {datSync[SYNC_STAGES-2:0], PS2_DAT};
      clkPrev <= clkSync[SYNC_STAGES-1];
    end
  end

  // bitCnt: 0 idle, 1..8 data bits, 9 parity, 10 stop.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      bitCnt     <= 4'd0;
      shiftReg   <= 8'h00;
      parBit     <= 1'b0;
      idleCnt    <= '0;
      byteOut    <= 8'h00;
      byteStrobe <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      byteStrobe <= 1'b0;
      frameErr   <= 1'b0;
      if (fall) begin
        idleCnt <= '0;
        case (bitCnt)
          4'd0: if (!datBit) bitCnt <= 4'd1;
          4'd9: begin
            parBit <= datBit;
            bitCnt <= 4'd10;
          end
          4'd10: begin
            bitCnt <= 4'd0;
            if (datBit && (^{shiftReg, parBit})) begin
              byteOut    <= shiftReg;
              byteStrobe <= 1'b1;
            end else begin
              frameErr <= 1'b1;
            end
          end
          default: begin
            shiftReg <= {datBit, shiftReg[7:1]};
            bitCnt   <= bitCnt + 4'd1;
          end
        endcase
      end else if (inFrame) begin
        if (timeout) begin
          bitCnt   <= 4'd0;
          idleCnt  <= '0;
          frameErr <= 1'b1;
        end else begin
          idleCnt <= idleCnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver top: E0/F0 prefix decoder, L/R modifier tracking and a
// first-word-fall-through event FIFO with sticky overflow.
module ps2_kbd_event_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int PASS_MODS   = 0
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      PS2_CLK,
  input  logic                      PS2_DAT,
  ps2_kbd_event_rx_if.master        evt,
  output logic [5:0]                oTagLive,
  output logic                      oFrameErr,
  output logic                      oOverflow,
  input  logic                      iClrOvf,
  output decState_t                 oDecState
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rxByte;
  logic       rxStrobe;
  logic       rxErr;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .byteOut    (rxByte),
    .byteStrobe (rxStrobe),
    .frameErr   (rxErr)
  );

  decState_t  state, stateNext;
  logic       emit, emitExt, emitBrk;
  logic [5:0] mask, tagNext;
  logic       pushReq;
  kbdEvent_t  pushEvt;

  always_comb begin
    stateNext = state;
    emit      = 1'b0;
    emitExt   = 1'b0;
    emitBrk   = 1'b0;
    if (rxErr) begin
      stateNext = DEC_IDLE;
    end else if (rxStrobe) begin
      case (state)
        DEC_IDLE: begin
          if (rxByte == CODE_E0)      stateNext = DEC_EXT;
          else if (rxByte == CODE_F0) stateNext = DEC_BRK;
          else                        emit = 1'b1;
        end
        DEC_EXT: begin
          emitExt = 1'b1;
          if (rxByte == CODE_F0)      stateNext = DEC_EXTBRK;
          else if (rxByte != CODE_E0) emit = 1'b1;
        end
        DEC_BRK: begin
          emitBrk = 1'b1;
          if (rxByte != CODE_E0 && rxByte != CODE_F0) emit = 1'b1;
        end
        DEC_EXTBRK: begin
          emitExt = 1'b1;
          emitBrk = 1'b1;
          if (rxByte != CODE_E0 && rxByte != CODE_F0) emit = 1'b1;
        end
        default: stateNext = DEC_IDLE;
      endcase
      if (emit) stateNext = DEC_IDLE;
    end
  end

  // The pushed tag already reflects this event's own modifier update.
  always_comb begin
    mask    = modMask(emitExt, rxByte);
    tagNext = emitBrk ? (oTagLive & ~mask) : (oTagLive | mask);
    pushReq = emit && ((mask == 6'd0) || (PASS_MODS != 0));
    pushEvt = '{ext: emitExt, brk: emitBrk, code: rxByte, tag: tagNext};
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= DEC_IDLE;
      oTagLive <= 6'd0;
    end else begin
      state <= stateNext;
      if (emit) oTagLive <= tagNext;
    end
  end

  assign oDecState = state;
  assign oFrameErr = rxErr;

  kbdEvent_t   mem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic        full, pop, doWrite;
  kbdEvent_t   head;

  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop     = evt.oValid && evt.iReady;
  assign doWrite = pushReq && (!full || pop);
  assign head    = mem[rdPtr[AW-1:0]];

  assign evt.oValid = (wrPtr != rdPtr);
  assign evt.oData  = evt.oValid ? head.code : 8'h00;
  assign evt.oExt   = evt.oValid ? head.ext  : 1'b0;
  assign evt.oBreak = evt.oValid ? head.brk  : 1'b0;
  assign evt.oTag   = evt.oValid ? head.tag  : 6'd0;

  always_ff @(posedge CLOCK) begin
    if (doWrite) mem[wrPtr[AW-1:0]] <= pushEvt;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      oOverflow <= 1'b0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)     rdPtr <= rdPtr + (AW+1)'(1);
      if (pushReq && full && !pop) oOverflow <= 1'b1;
      else if (iClrOvf)            oOverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// Bench for ps2_kbd_event_rx: drives PS/2 frames and compares the event stream against a
// byte-level reference model of the prefix/modifier rules and a bounded FIFO.
module tb_ps2_kbd_event_rx;
  import ps2_pkg::*;

  localparam int SYNC  = 2;
  localparam int TMO   = 200;
  localparam int DEPTH = 8;
  localparam int PASS  = 0;
  localparam int HALF  = 8;

  logic       CLOCK   = 1'b0;
  logic       RESET   = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       iClrOvf = 1'b0;
  logic [5:0] oTagLive;
  logic       oFrameErr;
  logic       oOverflow;
  decState_t  oDecState;

  ps2_kbd_event_rx_if bus ();

  ps2_kbd_event_rx #(
    .SYNC_STAGES (SYNC),
    .TIMEOUT_CYC (TMO),
    .FIFO_DEPTH  (DEPTH),
    .PASS_MODS   (PASS)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .evt       (bus.master),
    .oTagLive  (oTagLive),
    .oFrameErr (oFrameErr),
    .oOverflow (oOverflow),
    .iClrOvf   (iClrOvf),
    .oDecState (oDecState)
  );

  always #5 CLOCK = ~CLOCK;

  int checks    = 0;
  int errors    = 0;
  int errPulses = 0;

  // Reference model state: pending prefixes as flags, live tags, expected FIFO contents.
  logic [15:0] exp_q[$];
  logic        mExt = 1'b0;
  logic        mBrk = 1'b0;
  logic [5:0]  mTag = 6'd0;
  logic        mOvf = 1'b0;

  always @(negedge CLOCK) if (oFrameErr === 1'b1) errPulses++;

  function automatic logic [15:0] head();
    return {bus.oExt, bus.oBreak, bus.oData, bus.oTag};
  endfunction

  // Tag bit order {RAlt,LAlt,RCtrl,LCtrl,RShift,LShift}.
  function automatic int mod_bit(input logic ext, input logic [7:0] b);
    if (!ext && b == 8'h12) return 0;
    if (!ext && b == 8'h59) return 1;
    if (!ext && b == 8'h14) return 2;
    if ( ext && b == 8'h14) return 3;
    if (!ext && b == 8'h11) return 4;
    if ( ext && b == 8'h11) return 5;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int idx;
    if (b == 8'hE0) begin
      if (!mBrk) mExt = 1'b1;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else begin
      idx = mod_bit(mExt, b);
      if (idx >= 0) mTag[idx] = ~mBrk;
      if (idx < 0 || PASS != 0) begin
        if (exp_q.size() >= DEPTH) mOvf = 1'b1;
        else exp_q.push_back({mExt, mBrk, b, mTag});
      end
      mExt = 1'b0;
      mBrk = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mExt = 1'b0;
    mBrk = 1'b0;
    mTag = 6'd0;
    mOvf = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    tick(HALF);
    PS2_CLK = 1'b0;
    tick(HALF);
    PS2_CLK = 1'b1;
  endtask

  // kind: 0 good frame, 1 bad parity, 2 bad stop. popAtWrite pulses iReady in the FIFO write cycle.
  task automatic send_byte(input logic [7:0] b, input int kind, input bit popAtWrite);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b);
    if (kind == 1) par = ~par;
    bits = {(kind == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    PS2_DAT = bits[10];
    tick(HALF);
    PS2_CLK = 1'b0;
    tick(SYNC + 1);
    if (popAtWrite) begin
      bus.iReady = 1'b1;
      tick(1);
      bus.iReady = 1'b0;
    end else begin
      tick(1);
    end
    tick(HALF - SYNC - 2);
    PS2_CLK = 1'b1;
    if (popAtWrite && exp_q.size() != 0) void'(exp_q.pop_front());
    if (kind != 0) begin
      mExt = 1'b0;
      mBrk = 1'b0;
    end else begin
      model_byte(b);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    tick(3);
    checks++;
    if ({bus.oValid, head(), oTagLive, oFrameErr, oOverflow} !== 25'd0) begin
      errors++;
      $display("FAIL reset_held: got %h required 0", {bus.oValid, head(), oTagLive, oFrameErr, oOverflow});
    end
    RESET = 1'b1;
    tick(3);
    checks++;
    if ({bus.oValid, head(), oTagLive, oFrameErr, oOverflow} !== 25'd0) begin
      errors++;
      $display("FAIL reset_released: got %h required 0", {bus.oValid, head(), oTagLive, oFrameErr, oOverflow});
    end
  endtask

  task automatic test_latency();
    logic [7:0]  b;
    logic [10:0] bits;
    b = 8'h1C;
    bits = {1'b1, ~(^b), b, 1'b0};
    bus.iReady = 1'b1;
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    PS2_DAT = 1'b1;
    tick(HALF);
    PS2_CLK = 1'b0;
    tick(SYNC + 1);
    checks++;
    if (bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: oValid=%b required 0", bus.oValid);
    end
    tick(1);
    model_byte(b);
    checks++;
    if (bus.oValid !== 1'b1 || head() !== {2'b00, 8'h1C, 6'h00} || head() !== exp_q[0]) begin
      errors++;
      $display("FAIL latency_event: oValid=%b head=%h required 1/%h", bus.oValid, head(), exp_q[0]);
    end
    void'(exp_q.pop_front());
    tick(HALF - SYNC - 2);
    PS2_CLK = 1'b1;
    bus.iReady = 1'b0;
    checks++;
    if (bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL latency_popped: oValid=%b required 0", bus.oValid);
    end
  endtask

  task automatic test_modifier_tag();
    send_byte(8'hE0, 0, 0);
    send_byte(8'h14, 0, 0);
    send_byte(8'h1C, 0, 0);
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h14, 0, 0);
    tick(2);
    checks++;
    if (exp_q.size() != 1 || head() !== exp_q[0] || head() !== {2'b00, 8'h1C, 6'h08}) begin
      errors++;
      $display("FAIL modifier_event: head=%h required %h", head(), {2'b00, 8'h1C, 6'h08});
    end
    checks++;
    if (oTagLive !== mTag || oTagLive !== 6'd0) begin
      errors++;
      $display("FAIL modifier_live: oTagLive=%h required 00", oTagLive);
    end
    bus.iReady = 1'b1;
    tick(1);
    bus.iReady = 1'b0;
    exp_q.delete();
    checks++;
    if (bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL modifier_empty: oValid=%b required 0", bus.oValid);
    end
  endtask

  task automatic test_frame_error();
    int e0;
    send_byte(8'hE0, 0, 0);
    e0 = errPulses;
    send_byte(8'h1C, 1, 0);
    tick(2);
    checks++;
    if (errPulses - e0 != 1 || bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL parity_error: pulses=%0d oValid=%b required 1/0", errPulses - e0, bus.oValid);
    end
    e0 = errPulses;
    send_byte(8'h33, 2, 0);
    tick(2);
    checks++;
    if (errPulses - e0 != 1 || bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL stop_error: pulses=%0d oValid=%b required 1/0", errPulses - e0, bus.oValid);
    end
    send_byte(8'h75, 0, 0);
    tick(2);
    checks++;
    if (exp_q.size() != 1 || head() !== exp_q[0] || head() !== {2'b00, 8'h75, 6'h00}) begin
      errors++;
      $display("FAIL prefix_dropped: head=%h required %h", head(), {2'b00, 8'h75, 6'h00});
    end
    bus.iReady = 1'b1;
    tick(1);
    bus.iReady = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_timeout();
    int e0;
    e0 = errPulses;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    tick(TMO - 20);
    checks++;
    if (errPulses != e0) begin
      errors++;
      $display("FAIL timeout_early: pulses=%0d required 0", errPulses - e0);
    end
    tick(60);
    checks++;
    if (errPulses - e0 != 1 || bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: pulses=%0d oValid=%b required 1/0", errPulses - e0, bus.oValid);
    end
    mExt = 1'b0;
    mBrk = 1'b0;
    send_byte(8'h1C, 0, 0);
    tick(2);
    checks++;
    if (exp_q.size() != 1 || head() !== exp_q[0] || head() !== {2'b00, 8'h1C, 6'h00}) begin
      errors++;
      $display("FAIL timeout_recover: head=%h required %h", head(), {2'b00, 8'h1C, 6'h00});
    end
    bus.iReady = 1'b1;
    tick(1);
    bus.iReady = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] c;
    for (int i = 0; i <= DEPTH; i++) begin
      c = 8'h16 + 8'(i);
      send_byte(c, 0, 0);
    end
    tick(2);
    checks++;
    if (oOverflow !== mOvf || oOverflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: oOverflow=%b required 1", oOverflow);
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (bus.oValid !== 1'b1) break;
      checks++;
      if (exp_q.size() == 0 || head() !== exp_q[0] || bus.oData !== 8'h16 + 8'(k)) begin
        errors++;
        $display("FAIL overflow_drain: head=%h required code %h", head(), 8'h16 + 8'(k));
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      bus.iReady = 1'b1;
      tick(1);
      bus.iReady = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0 || bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_count: left=%0d oValid=%b required 0/0", exp_q.size(), bus.oValid);
    end
    exp_q.delete();
    iClrOvf = 1'b1;
    tick(1);
    iClrOvf = 1'b0;
    mOvf = 1'b0;
    checks++;
    if (oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: oOverflow=%b required 0", oOverflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] c;
    for (int i = 0; i < DEPTH; i++) begin
      c = 8'h20 + 8'(i);
      send_byte(c, 0, 0);
    end
    send_byte(8'h28, 0, 1);
    tick(2);
    checks++;
    if (oOverflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_overflow: oOverflow=%b required 0", oOverflow);
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (bus.oValid !== 1'b1) break;
      checks++;
      if (exp_q.size() == 0 || head() !== exp_q[0]) begin
        errors++;
        $display("FAIL fullpop_drain: head=%h required %h", head(), (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      bus.iReady = 1'b1;
      tick(1);
      bus.iReady = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fullpop_count: %0d events missing, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h12, 0, 0);
    send_byte(8'h1C, 0, 0);
    send_byte(8'hF0, 0, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    PS2_DAT = 1'b1;
    tick(3);
    RESET = 1'b0;
    tick(2);
    checks++;
    if ({bus.oValid, head(), oTagLive, oFrameErr, oOverflow} !== 25'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h required 0", {bus.oValid, head(), oTagLive, oFrameErr, oOverflow});
    end
    RESET = 1'b1;
    model_reset();
    tick(5);
    send_byte(8'h1C, 0, 0);
    tick(2);
    checks++;
    if (exp_q.size() != 1 || head() !== exp_q[0] || head() !== {2'b00, 8'h1C, 6'h00}) begin
      errors++;
      $display("FAIL midreset_recover: head=%h required %h", head(), {2'b00, 8'h1C, 6'h00});
    end
    bus.iReady = 1'b1;
    tick(1);
    bus.iReady = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    int         n, sel, kind;
    for (int r = 0; r < 15; r++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0: b = 8'hE0;
          1: b = 8'hF0;
          2: b = 8'h12;
          3: b = 8'h59;
          4: b = 8'h14;
          5: b = 8'h11;
          default: b = 8'($urandom_range(1, 255));
        endcase
        kind = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
        send_byte(b, kind, 0);
      end
      tick(2);
      checks++;
      if (oTagLive !== mTag || oOverflow !== 1'b0) begin
        errors++;
        $display("FAIL random_live: oTagLive=%h oOverflow=%b required %h/0", oTagLive, oOverflow, mTag);
      end
      for (int k = 0; k < DEPTH + 2; k++) begin
        if (bus.oValid !== 1'b1) break;
        checks++;
        if (exp_q.size() == 0 || head() !== exp_q[0]) begin
          errors++;
          $display("FAIL random_event: round %0d head=%h required %h", r, head(), (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        bus.iReady = 1'b1;
        tick(1);
        bus.iReady = 1'b0;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_missing: round %0d %0d events not delivered", r, exp_q.size());
      end
      exp_q.delete();
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.iReady = 1'b0;
    test_reset();
    test_latency();
    test_modifier_tag();
    test_frame_error();
    test_timeout();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
